// File: rtl/mux4_rr_sequencer.sv
// Round-robin sequencer driving a 4:1 mux select: arbitrates req, holds sel
// steady while capturing mux_y, hands data off on valid/ready and acks the channel.
module mux4_rr_sequencer #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] mux_y,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        ack,
  output logic [7:0]        grant_cnt
);

  typedef enum logic [1:0] {IDLE, SAMPLE, OUT} state_t;

  state_t            state, state_nxt;
  logic [1:0]        sel_nxt;
  logic [1:0]        last, last_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              valid_nxt;
  logic [3:0]        ack_nxt;
  logic [7:0]        cnt_nxt;
  logic [3:0]        req_eff;

  // First requester searching upward from the channel after 'from', wrapping
  // around so that 'from' itself is considered last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] from);
    logic [1:0] idx;
    logic [1:0] win;
    win = from;
    for (int k = 4; k >= 1; k--) begin
      idx = from + 2'(k);
      if (r[idx]) win = idx;
    end
    return win;
  endfunction

  // A channel just acknowledged cannot be re-granted from its stale request.
  assign req_eff = req & ~ack;

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    last_nxt  = last;
    data_nxt  = out_data;
    valid_nxt = out_valid;
    ack_nxt   = 4'b0000;
    cnt_nxt   = grant_cnt;
    case (state)
      IDLE: begin
        if (|req_eff) begin
          sel_nxt   = rr_pick(req_eff, last);
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        data_nxt  = mux_y;
        valid_nxt = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        if (out_valid && out_ready) begin
          valid_nxt = 1'b0;
          ack_nxt   = 4'b0001 << sel;
          last_nxt  = sel;
          cnt_nxt   = grant_cnt + 8'd1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last resets to 3 so the first arbitration after reset favours channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 2'd0;
      last      <= 2'd3;
      out_data  <= '0;
      out_valid <= 1'b0;
      ack       <= 4'b0000;
      grant_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      last      <= last_nxt;
      out_data  <= data_nxt;
      out_valid <= valid_nxt;
      ack       <= ack_nxt;
      grant_cnt <= cnt_nxt;
    end
  end

endmodule
